// File: rtl/fb_writer_if.sv
`default_nettype none
// fb_writer_if: window control, pixel stream, RAM write port and status of fb_writer.
// Rev 1.0
interface fb_writer_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [9:0]        win_w;
  logic [9:0]        win_h;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [ADDR_W-1:0] wraddress;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, base_addr, win_w, win_h, s_data, s_valid, s_last,
    input  s_ready, wraddress, data, wren, busy, done, err
  );

  modport slave (
    input  start, base_addr, win_w, win_h, s_data, s_valid, s_last,
    output s_ready, wraddress, data, wren, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/fb_writer.sv
`default_nettype none
// fb_writer: writes a valid/ready pixel stream in raster order into a window of the framebuffer RAM.
// Rev 1.0
module fb_writer #(
  parameter int IMG_W  = 512,
  parameter int IMG_H  = 512,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  fb_writer_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [10:0]       c_img_w    = 11'(IMG_W);
  localparam logic [10:0]       c_img_h    = 11'(IMG_H);
  localparam logic [ADDR_W-1:0] c_row_step = ADDR_W'(IMG_W);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [9:0]        r_win_w;
  logic [9:0]        r_win_h;
  logic [9:0]        r_col;
  logic [9:0]        r_row;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_wraddress;
  logic [DATA_W-1:0] r_data;
  logic              r_wren;
  logic              r_err;

  logic w_s_ready;
  logic w_busy;
  logic w_done;
  logic w_accept;
  logic w_last_col;
  logic w_final;
  logic w_zero;
  logic w_oversize;

  assign w_zero     = (bus.win_w == 10'd0) || (bus.win_h == 10'd0);
  assign w_oversize = ({1'b0, bus.win_w} > c_img_w) || ({1'b0, bus.win_h} > c_img_h);
  assign w_accept   = bus.s_valid && w_s_ready;
  assign w_last_col = (r_col == r_win_w - 10'd1);
  assign w_final    = w_last_col && (r_row == r_win_h - 10'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next = (w_zero || w_oversize) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // An early s_last aborts the window after its own beat is written.
        if (w_accept && (w_final || bus.s_last)) begin
          w_next = S_FLUSH;
        end
      end
      S_FLUSH: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_s_ready = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_RUN: begin
        w_s_ready = 1'b1;
        w_busy    = 1'b1;
      end
      S_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win_w     <= '0;
      r_win_h     <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_row_base  <= '0;
      r_wraddress <= '0;
      r_data      <= '0;
      r_wren      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      if (r_state == S_IDLE && bus.start) begin
        r_win_w    <= bus.win_w;
        r_win_h    <= bus.win_h;
        r_col      <= '0;
        r_row      <= '0;
        r_row_base <= bus.base_addr;
        r_err      <= w_oversize && !w_zero;
      end else if (w_accept) begin
        r_wren      <= 1'b1;
        r_data      <= bus.s_data;
        r_wraddress <= r_row_base + ADDR_W'(r_col);
        if (w_last_col) begin
          r_col      <= '0;
          r_row      <= r_row + 10'd1;
          r_row_base <= r_row_base + c_row_step;
        end else begin
          r_col <= r_col + 10'd1;
        end
        if (bus.s_last && !w_final) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.wraddress = r_wraddress;
  assign bus.data      = r_data;
  assign bus.wren      = r_wren;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fb_writer.sv
`default_nettype none
// tb_fb_writer: table-driven and randomized windows checked against a raster-order write model.
// Rev 1.0
module tb_fb_writer;
  localparam int IMG_W  = 512;
  localparam int IMG_H  = 512;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fb_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // last_beat: 0 = s_last on the final beat, -1 = never, k>0 = on beat k (1-based)
  typedef struct {
    logic [17:0] base;
    int          w;
    int          h;
    int          last_beat;
    int          vmode;
    bit          mid_start;
    logic [7:0]  seed;
    bit          exp_err;
    int          exp_nwr;
  } vec_t;

  int n_vec = 0;
  int n_mis = 0;

  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];
  logic [ADDR_W-1:0] cap_addr[$];
  logic [DATA_W-1:0] cap_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic bit last_for(input vec_t v, input int k);
    if (v.last_beat == 0)     return (k == v.w * v.h - 1);
    else if (v.last_beat > 0) return (k + 1 == v.last_beat);
    else                      return 1'b0;
  endfunction

  // Expected writes: beat k lands at base + (k / w) * IMG_W + (k % w), modulo the address space.
  task automatic model(input vec_t v, output int n_send, output bit err);
    int n;
    int a;
    n = v.w * v.h;
    exp_addr.delete();
    exp_data.delete();
    if (v.w == 0 || v.h == 0) begin
      n_send = 0; err = 1'b0;
    end else if (v.w > IMG_W || v.h > IMG_H) begin
      n_send = 0; err = 1'b1;
    end else if (v.last_beat > 0 && v.last_beat < n) begin
      n_send = v.last_beat; err = 1'b1;
    end else begin
      n_send = n; err = 1'b0;
    end
    for (int k = 0; k < n_send; k++) begin
      a = (int'(v.base) + (k / v.w) * IMG_W + (k % v.w)) % (1 << ADDR_W);
      exp_addr.push_back(ADDR_W'(a));
      exp_data.push_back(DATA_W'(int'(v.seed) + k));
    end
  endtask

  task automatic run_job(input vec_t v, input bit req_err, input int req_nwr, input string tag);
    int  n_send;
    bit  merr;
    int  beats;
    int  cyc;
    int  done_cyc;
    int  budget;
    bit  acc;
    bit  hold;
    bit  wren_bad;
    bit  ready_bad;
    bit  busy_at_done;
    int  nc;

    model(v, n_send, merr);
    cap_addr.delete();
    cap_data.delete();
    budget    = 8 * v.w * v.h + 40;
    beats     = 0;
    cyc       = 0;
    done_cyc  = -1;
    wren_bad  = 1'b0;
    ready_bad = 1'b0;
    busy_at_done = 1'b0;

    @(negedge clk);
    bus.start     = 1'b1;
    bus.base_addr = v.base;
    bus.win_w     = 10'(v.w);
    bus.win_h     = 10'(v.h);
    bus.s_valid   = (n_send > 0) && (v.vmode == 0 || (v.vmode == 2 && $urandom_range(0, 1) == 1));
    bus.s_data    = DATA_W'(int'(v.seed));
    bus.s_last    = last_for(v, 0);
    acc = bus.s_valid && bus.s_ready;

    while (done_cyc < 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      bus.start     = 1'b0;
      bus.base_addr = v.base;
      bus.win_w     = 10'(v.w);
      bus.win_h     = 10'(v.h);
      if (acc) beats++;
      if (bus.wren !== acc) wren_bad = 1'b1;
      if (bus.wren === 1'b1) begin
        cap_addr.push_back(bus.wraddress);
        cap_data.push_back(bus.data);
      end
      if (beats >= n_send && bus.s_ready !== 1'b0) ready_bad = 1'b1;
      if (bus.done === 1'b1) begin
        done_cyc     = cyc;
        busy_at_done = bus.busy;
      end else begin
        hold = bus.s_valid && !acc;
        if (beats < n_send) begin
          if (!hold) begin
            case (v.vmode)
              0:       bus.s_valid = 1'b1;
              1:       bus.s_valid = (cyc % 2 == 1);
              default: bus.s_valid = ($urandom_range(0, 1) == 1);
            endcase
            bus.s_data = DATA_W'(int'(v.seed) + beats);
            bus.s_last = last_for(v, beats);
          end
        end else begin
          bus.s_valid = 1'b0;
          bus.s_last  = 1'b0;
        end
        if (v.mid_start && cyc == 3 && beats < n_send) begin
          bus.start     = 1'b1;
          bus.base_addr = ~v.base;
          bus.win_w     = 10'd3;
          bus.win_h     = 10'd1;
        end
        acc = bus.s_valid && bus.s_ready;
      end
    end

    chk({tag, "_done_seen"}, 32'(done_cyc >= 0), 32'd1);
    if (v.vmode == 0)
      chk({tag, "_done_cycle"}, 32'(done_cyc), 32'((n_send == 0) ? 1 : n_send + 2));
    chk({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    chk({tag, "_wren_lag"}, 32'(wren_bad), 32'd0);
    chk({tag, "_ready_drop"}, 32'(ready_bad), 32'd0);

    @(negedge clk);
    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk({tag, "_err"}, 32'(bus.err), 32'(req_err));
    chk({tag, "_post"}, {29'd0, bus.done, bus.s_ready, bus.wren}, 32'd0);
    chk({tag, "_nwr"}, 32'(cap_addr.size()), 32'(req_nwr));
    nc = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
    for (int i = 0; i < nc; i++)
      chk({tag, $sformatf("_wr%0d", i)}, 32'({cap_addr[i], cap_data[i]}), 32'({exp_addr[i], exp_data[i]}));
  endtask

  vec_t tbl[11];
  vec_t rv;
  int   rn;
  int   wcnt;
  int   rsend;
  bit   rerr;

  initial begin
    tbl[0]  = '{18'h00000,   4,   2,  0, 0, 1'b0, 8'h10, 1'b0,   8};
    tbl[1]  = '{18'h00000,   4,   2,  0, 1, 1'b0, 8'h10, 1'b0,   8};
    tbl[2]  = '{18'h00100,   3,   3,  5, 0, 1'b0, 8'h20, 1'b1,   5};
    tbl[3]  = '{18'h00100,   3,   3,  0, 0, 1'b0, 8'h30, 1'b0,   9};
    tbl[4]  = '{18'h00200,   0,   3,  0, 0, 1'b0, 8'h40, 1'b0,   0};
    tbl[5]  = '{18'h00200, 600,   2,  0, 0, 1'b0, 8'h50, 1'b1,   0};
    tbl[6]  = '{18'h3FFFE,   4,   1,  0, 0, 1'b0, 8'h60, 1'b0,   4};
    tbl[7]  = '{18'h00020,   5,   3,  0, 0, 1'b1, 8'h70, 1'b0,  15};
    tbl[8]  = '{18'h00010,   3,   2, -1, 2, 1'b0, 8'h80, 1'b0,   6};
    tbl[9]  = '{18'h00030,   2, 600,  0, 0, 1'b0, 8'h90, 1'b1,   0};
    tbl[10] = '{18'h3FF80, 512,   1,  0, 0, 1'b0, 8'hA0, 1'b0, 512};

    reset = 1'b0;
    bus.start = 1'b0; bus.base_addr = '0; bus.win_w = '0; bus.win_h = '0;
    bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {bus.s_ready, bus.wren, bus.busy, bus.done, bus.err, bus.wraddress, bus.data}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++)
      run_job(tbl[i], tbl[i].exp_err, tbl[i].exp_nwr, $sformatf("tbl%0d", i));

    // Reset in the middle of a 4x4 window, then a clean rerun.
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 18'h00040; bus.win_w = 10'd4; bus.win_h = 10'd4;
    bus.s_valid = 1'b1; bus.s_data = 8'hC0; bus.s_last = 1'b0;
    wcnt = 0;
    for (int c = 0; c < 20 && wcnt < 2; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.wren === 1'b1) wcnt++;
    end
    chk("midreset_two_writes", 32'(wcnt), 32'd2);
    reset = 1'b0;
    #1;
    chk("midreset_outputs", {bus.s_ready, bus.wren, bus.busy, bus.done, bus.err, bus.wraddress, bus.data}, 32'd0);
    bus.s_valid = 1'b0;
    wcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.wren === 1'b1 || bus.done === 1'b1) wcnt++;
    end
    chk("midreset_quiet", 32'(wcnt), 32'd0);
    reset = 1'b1;
    rv = '{18'h00040, 4, 4, 0, 0, 1'b0, 8'hC0, 1'b0, 16};
    run_job(rv, 1'b0, 16, "after_reset");

    for (int j = 0; j < 20; j++) begin
      rv.base = 18'($urandom);
      rv.w    = $urandom_range(1, 8);
      rv.h    = $urandom_range(1, 6);
      rn      = rv.w * rv.h;
      case ($urandom_range(0, 3))
        0:       rv.last_beat = 0;
        1:       rv.last_beat = -1;
        default: rv.last_beat = $urandom_range(1, rn);
      endcase
      rv.vmode     = $urandom_range(0, 2);
      rv.mid_start = ($urandom_range(0, 1) == 1);
      rv.seed      = 8'($urandom);
      model(rv, rsend, rerr);
      rv.exp_err = rerr;
      rv.exp_nwr = rsend;
      run_job(rv, rerr, rsend, $sformatf("rnd%0d", j));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fb_writer.md
Name: fb_writer

Overview:
- Write-side companion to the VGA framebuffer read path: fills the dual-port pixel RAM whose read port is indexed by an 18-bit address with 8-bit data.
- Accepts a valid/ready pixel stream and writes it in raster order into a rectangular window of an IMG_W-wide frame starting at a programmable base address.
- Feeds the RAM write port (wraddress/data/wren); raises done when the window is complete.

Parameters:
- IMG_W, 512, frame row pitch in pixels, used to advance rows.
- IMG_H, 512, frame height in rows, used for window bound checks.
- ADDR_W, 18, RAM address width.
- DATA_W, 8, pixel width.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; latches base_addr, win_w and win_h.
- base_addr  input  ADDR_W  address of the window's top-left pixel.
- win_w  input  10  window width in pixels.
- win_h  input  10  window height in rows.
- s_data  input  DATA_W  stream pixel.
- s_valid  input  1  stream beat valid.
- s_last  input  1  asserted by the source on the final beat of the window.
- s_ready  output  1  block can accept a beat.
- wraddress  output  ADDR_W  RAM write address.
- data  output  DATA_W  RAM write data.
- wren  output  1  RAM write enable.
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.
- err  output  1  sticky error, cleared by the next accepted start.

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE. s_ready, wren, busy, done and err are 0. wraddress, data, col, row and row_base are 0.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start=1 latches the inputs and clears err.
  - If win_w=0 or win_h=0: go to DONE with err=0.
  - If win_w>IMG_W or win_h>IMG_H: go to DONE with err=1.
  - Otherwise: go to RUN with col=0, row=0, row_base=base_addr.
- RUN:
  - s_ready=1 and busy=1.
  - A beat is accepted when s_valid and s_ready are both high.
  - Cycle after acceptance: wren=1, data=s_data, wraddress=row_base+col (mod 2^ADDR_W). Latency is 1 cycle, with no write-side backpressure.
  - After each accepted beat:
    - if col=win_w-1: col=0, row=row+1, row_base=row_base+IMG_W (mod 2^ADDR_W);
    - else: col=col+1.
  - Final beat (col=win_w-1 and row=win_h-1): go to FLUSH; s_ready drops the next cycle.
  - s_last must coincide with the final beat. If s_last=1 on any earlier beat: that beat is still written, err=1, go to FLUSH (abort).
  - If s_last=0 on the final beat: the window still completes, and err=0.
- FLUSH: s_ready=0 while the last write issues (wren=1); go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Output defaults: wren=0 whenever no beat was accepted the previous cycle. data and wraddress hold their last values.
- start is ignored in RUN, FLUSH and DONE; latched window parameters do not change mid-run.
- s_valid while s_ready=0 is not accepted. The source must hold the beat; the block does not buffer.
- Address wrap: a window extending past 2^ADDR_W-1 wraps to 0 with no error.
- Reset mid-run: immediate return to IDLE, with no done pulse and no further writes.
- Throughput: one pixel per clock when s_valid is held high. Total cycles from start to done = 1 (latch) + N beats + 1 (flush) + 1 (done), where N = win_w*win_h.

Test Plan:
- Basic window: base=0, win_w=4, win_h=2, IMG_W=512, s_valid held high, data 0x10..0x17.
  - Writes at addresses 0,1,2,3,512,513,514,515 with data 0x10..0x17.
  - s_last on beat 8; done pulses 1 cycle after the last wren; err=0.
- Backpressure gaps: same window, s_valid toggling 1,0,1,0.
  - Exactly 8 writes, addresses unchanged, no duplicates.
  - Each wren lags its accepted beat by exactly 1 cycle.
- Early s_last: win_w=3, win_h=3, s_last on beat 5.
  - 5 writes (last at base+512+1), err=1, done pulse, s_ready=0 afterwards.
  - A new start clears err.
- Degenerate and oversized windows:
  - win_w=0: done pulse 1 cycle after start, no wren, err=0.
  - win_w=600: done pulse, no wren, err=1.
- Wrap and reset:
  - base=0x3FFFE, win_w=4, win_h=1: writes 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
  - Assert reset after beat 2 of a 4x4 window: all outputs 0 immediately, no done; restart completes normally.
- start while busy: pulse start with new base_addr mid-RUN; it is ignored and the original window's addresses complete unchanged.
